// File: rtl/cola_payer_fsm_pkg.sv
// cola_pkg: shared states, coin modes and widths for cola_payer_fsm
package cola_pkg;
  typedef enum logic [2:0] {IDLE, PAY, GAP, WAIT, DONE, ERR} state_t;
  localparam logic [1:0] MODE_HALF = 2'd0;
  localparam logic [1:0] MODE_ONE = 2'd1;
  localparam logic [1:0] MODE_MIX = 2'd2;
  localparam int PRICE_HALF_DEF = 5;
  localparam int PAID_W = 8;
  localparam int GAP_W = 4;
  localparam int TMO_W = 8;
  function automatic logic coin_is_one(input logic [1:0] mode, input logic [1:0] idx);
    return mode == MODE_HALF ? 1'b0 : (mode & MODE_MIX) != 2'd0 ? idx < 2'd2 : mode == MODE_ONE;
  endfunction
endpackage

// File: rtl/cola_payer_fsm_coin_pulse_gen.sv
// coin_pulse_gen: exclusive one-cycle coin pulses plus the inter-coin gap counter
module coin_pulse_gen import cola_pkg::*; #(
  parameter int GAP_CYC = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic req,
  input  logic is_one,
  input  logic gap_load,
  output logic po_money_half,
  output logic po_money_one,
  output logic ready
);
  // loaded one short so the return to PAY lands the next coin GAP_CYC idle cycles later
  localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(GAP_CYC == 0 ? 0 : GAP_CYC - 1);
  logic [GAP_W-1:0] gap_cnt;
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      po_money_half <= 1'b0;
      po_money_one <= 1'b0;
      gap_cnt <= '0;
    end else begin
      po_money_half <= req & ~is_one;
      po_money_one <= req & is_one;
      gap_cnt <= gap_load ? GAP_LD : gap_cnt - GAP_W'(gap_cnt != '0);
    end
  end
  assign ready = gap_cnt == '0;
endmodule

// File: rtl/cola_payer_fsm.sv
// cola_payer_fsm: customer-side coin driver for the cola vending FSM
// COLA_PAYER_STAT_EN adds spent_total, the cumulative half-yuan units inserted since reset
module cola_payer_fsm import cola_pkg::*; #(
  parameter int PRICE_HALF = PRICE_HALF_DEF,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [3:0] buy_num,
  input  logic [1:0] coin_mode,
  input  logic       pi_cola,
  input  logic       pi_change,
  output logic       po_money_half,
  output logic       po_money_one,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] cola_cnt,
  output logic [3:0] change_cnt
`ifdef COLA_PAYER_STAT_EN
  ,output logic [15:0] spent_total
`endif
);
  state_t state, nxt;
  logic [3:0] buy_q;
  logic [1:0] mode_q, coin_idx;
  logic [PAID_W-1:0] paid, paid_nxt;
  logic [TMO_W-1:0] tmo;
  logic req, is_one, gap_load, ready, cola_hit;
  always_comb begin
    nxt = state;
    req = 1'b0;
    gap_load = 1'b0;
    is_one = coin_is_one(mode_q, coin_idx);
    paid_nxt = paid + (is_one ? PAID_W'(2) : PAID_W'(1));
    cola_hit = state == WAIT && pi_cola;
    case (state)
      IDLE: nxt = !start ? IDLE : buy_num == 4'd0 ? DONE : PAY;
      PAY: begin
        req = 1'b1;
        gap_load = paid_nxt < PAID_W'(PRICE_HALF) && GAP_CYC != 0;
        nxt = paid_nxt >= PAID_W'(PRICE_HALF) ? WAIT : GAP_CYC == 0 ? PAY : GAP;
      end
      GAP: nxt = ready ? PAY : GAP;
      WAIT: begin
        gap_load = pi_cola;
        nxt = pi_cola ? (cola_cnt + 4'd1 == buy_q ? DONE : GAP_CYC == 0 ? PAY : GAP)
                      : tmo + TMO_W'(1) == TMO_W'(TIMEOUT_CYC) ? ERR : WAIT;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      cola_cnt <= '0;
      change_cnt <= '0;
      buy_q <= '0;
      mode_q <= '0;
      coin_idx <= '0;
      paid <= '0;
      tmo <= '0;
    end else begin
      state <= nxt;
      busy <= nxt != IDLE;
      done <= state == DONE;
      tmo <= state == WAIT ? tmo + TMO_W'(1) : '0;
      if (state == IDLE && start) begin
        buy_q <= buy_num;
        mode_q <= coin_mode;
        cola_cnt <= '0;
        change_cnt <= '0;
        err <= 1'b0;
        paid <= '0;
        coin_idx <= '0;
      end else begin
        if (req) begin
          paid <= paid_nxt;
          coin_idx <= coin_idx + 2'(coin_idx != 2'd3);
        end
        if (cola_hit) begin
          cola_cnt <= cola_cnt + 4'd1;
          paid <= '0;
          coin_idx <= '0;
        end
        if (state != IDLE && pi_change && change_cnt != 4'hF) change_cnt <= change_cnt + 4'd1;
        if (nxt == ERR) err <= 1'b1;
      end
    end
  end
`ifdef COLA_PAYER_STAT_EN
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) spent_total <= '0;
    else if (req) spent_total <= spent_total + (is_one ? 16'd2 : 16'd1);
  end
`endif
  coin_pulse_gen #(.GAP_CYC(GAP_CYC)) u_coin (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .req(req),
    .is_one(is_one),
    .gap_load(gap_load),
    .po_money_half(po_money_half),
    .po_money_one(po_money_one),
    .ready(ready)
  );
endmodule

// File: tb/tb_cola_payer_fsm.sv
// tb_cola_payer_fsm: directed checks of cola_payer_fsm against a small vending machine model
module tb_cola_payer_fsm;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] buy_num = '0;
  logic [1:0] coin_mode = '0;
  logic pi_cola, pi_change;
  logic po_money_half, po_money_one, busy, done, err;
  logic [3:0] cola_cnt, change_cnt;
`ifdef COLA_PAYER_STAT_EN
  logic [15:0] spent_total;
`endif
  int n_chk = 0, n_fail = 0;
  int n_half = 0, n_one = 0, acc = 0, cyc = 0, last_coin = -1, bad_gap = 0;
  logic both = 1'b0;
  logic [15:0] seq = '0;
  logic model_en = 1'b0;
  int h0, o0, lat, e_at, busy_e, busy_e1;
  logic d_seen;

  always #5 sys_clk = ~sys_clk;

  cola_payer_fsm dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .start(start),
    .buy_num(buy_num),
    .coin_mode(coin_mode),
    .pi_cola(pi_cola),
    .pi_change(pi_change),
    .po_money_half(po_money_half),
    .po_money_one(po_money_one),
    .busy(busy),
    .done(done),
    .err(err),
    .cola_cnt(cola_cnt),
    .change_cnt(change_cnt)
`ifdef COLA_PAYER_STAT_EN
    ,.spent_total(spent_total)
`endif
  );

  always @(posedge sys_clk) cyc++;

  // vending machine: 5 half-units buy a cola, a sixth returns one half-yuan change
  always @(negedge sys_clk) begin
    if (po_money_half && po_money_one) both = 1'b1;
    if (po_money_half || po_money_one) begin
      if (last_coin >= 0 && cyc - last_coin != 3) bad_gap++;
      last_coin = cyc;
      seq = {seq[14:0], po_money_one};
      n_half += int'(po_money_half);
      n_one += int'(po_money_one);
      acc += po_money_one ? 2 : 1;
    end
    pi_cola = 1'b0;
    pi_change = 1'b0;
    if (!model_en) acc = 0;
    else if (acc >= 5) begin
      pi_cola = 1'b1;
      pi_change = acc >= 6;
      acc = 0;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic go(input int n, input int m);
    buy_num = 4'(n);
    coin_mode = 2'(m);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int l);
    l = -1;
    for (int i = 1; i <= lim; i++) begin
      tick();
      if (done) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_cola"}, int'(cola_cnt), 0);
    chk({tag, "_change"}, int'(change_cnt), 0);
    chk({tag, "_half"}, int'(po_money_half), 0);
    chk({tag, "_one"}, int'(po_money_one), 0);
  endtask

  initial begin
    tick();
    tick();
    chk_idle_zero("reset");
    sys_rst_n = 1'b1;
    tick();

    model_en = 1'b1;
    h0 = n_half;
    o0 = n_one;
    go(1, 0);
    wait_done(40, lat);
    chk("m0_done_latency", lat, 15);
    chk("m0_cola", int'(cola_cnt), 1);
    chk("m0_change", int'(change_cnt), 0);
    chk("m0_half_coins", n_half - h0, 5);
    chk("m0_one_coins", n_one - o0, 0);
    chk("m0_coin_spacing_errors", bad_gap, 0);
    chk("m0_busy_at_done", int'(busy), 0);
    tick();
    chk("m0_done_one_cycle", int'(done), 0);
    chk("m0_busy_after", int'(busy), 0);

    h0 = n_half;
    o0 = n_one;
    go(2, 1);
    wait_done(80, lat);
    chk("m1_done_latency", lat, 19);
    chk("m1_one_coins", n_one - o0, 6);
    chk("m1_half_coins", n_half - h0, 0);
    chk("m1_cola", int'(cola_cnt), 2);
    chk("m1_change", int'(change_cnt), 2);
    chk("m1_err", int'(err), 0);

    h0 = n_half;
    o0 = n_one;
    go(3, 2);
    wait_done(80, lat);
    chk("m2_done_latency", lat, 29);
    chk("m2_coin_sequence", int'(seq[8:0]), 'b110110110);
    chk("m2_one_coins", n_one - o0, 6);
    chk("m2_half_coins", n_half - h0, 3);
    chk("m2_cola", int'(cola_cnt), 3);
    chk("m2_change", int'(change_cnt), 0);

    model_en = 1'b0;
    e_at = -1;
    busy_e = -1;
    busy_e1 = -1;
    d_seen = 1'b0;
    go(1, 0);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done) d_seen = 1'b1;
      if (e_at >= 0 && busy_e1 < 0) busy_e1 = int'(busy);
      if (err && e_at < 0) begin
        e_at = i;
        busy_e = int'(busy);
      end
    end
    chk("tmo_err_cycle", e_at, 21);
    chk("tmo_busy_with_err", busy_e, 1);
    chk("tmo_busy_after_err", busy_e1, 0);
    chk("tmo_no_done", int'(d_seen), 0);
    chk("tmo_err_sticky", int'(err), 1);
    chk("tmo_cola", int'(cola_cnt), 0);
    model_en = 1'b1;
    go(1, 0);
    chk("tmo_err_cleared", int'(err), 0);
    wait_done(40, lat);
    chk("tmo_rerun_latency", lat, 15);

    model_en = 1'b0;
    go(2, 0);
    tick();
    chk("abort_first_coin", int'(po_money_half), 1);
    buy_num = 4'd1;
    coin_mode = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_busy_in_gap", int'(busy), 1);
    tick();
    tick();
    chk("abort_restart_ignored_half", int'(po_money_half), 1);
    chk("abort_restart_ignored_one", int'(po_money_one), 0);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    chk_idle_zero("abort_reset");
    tick();
    chk("abort_no_half_after", int'(po_money_half), 0);
    chk("abort_no_one_after", int'(po_money_one), 0);
    chk("abort_idle_after", int'(busy), 0);

    h0 = n_half;
    o0 = n_one;
    go(0, 0);
    chk("zero_busy_in_done", int'(busy), 1);
    wait_done(5, lat);
    chk("zero_done_latency", lat, 1);
    chk("zero_no_coins", (n_half - h0) + (n_one - o0), 0);

`ifdef COLA_PAYER_STAT_EN
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();
    chk("stat_reset", int'(spent_total), 0);
    model_en = 1'b1;
    go(1, 0);
    wait_done(40, lat);
    chk("stat_after_m0", int'(spent_total), 5);
    go(1, 1);
    wait_done(40, lat);
    chk("stat_after_m1", int'(spent_total), 11);
`endif

    chk("coin_exclusive", int'(both), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
